// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM state codes and
// frame geometry. Used by both the PISO transmitter and the SIPO receiver.
package uart_pkg;

  // Parity selection; both "none" codes behave identically.
  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  // Receiver FSM state codes.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int DATA_BITS = 8;

  // True when the frame carries a parity bit.
  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer for the asynchronous serial line. Resets to 1 so
// the idle-high line never looks like a start bit coming out of reset.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic baud_clk,
  input  logic reset_n,
  input  logic data_async,
  output logic data_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw line through the flop chain.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_async};
    end
  end

  assign data_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_sipo_rx.sv
// UART receive frame decoder with serial-in/parallel-out shift register.
// Oversamples the synchronized line, samples each bit at its centre, checks
// parity and stop bit and presents the byte with a one-cycle done pulse.
//
// Handshake: done_flag is a one-cycle valid strobe with no ready/back-pressure;
// data_out, parity_error and frame_error are valid on that cycle and hold
// until the next done_flag.
module uart_sipo_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic                 data_rx,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done_flag,
  output logic                 active_flag,
  output logic                 parity_error,
  output logic                 frame_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  // Mid start bit is half a bit after t0; later samples are a full bit apart.
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           par_type_q;
  logic                 par_bit;
  logic                 par_err_next;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .baud_clk  (baud_clk),
    .reset_n   (reset_n),
    .data_async(data_rx),
    .data_sync (rx_s)
  );

  // Parity verdict for the frame being closed, from the latched parity type.
  always_comb begin
    par_err_next = 1'b0;
    case (par_type_q)
      PAR_ODD:  par_err_next = ((^shift_reg) ^ par_bit) != 1'b1;
      PAR_EVEN: par_err_next = ((^shift_reg) ^ par_bit) != 1'b0;
      default:  par_err_next = 1'b0;
    endcase
  end

  // Frame FSM, tick/bit counters, shift register and output registers.
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_type_q   <= PAR_NONE0;
      par_bit      <= 1'b0;
      data_out     <= '0;
      done_flag    <= 1'b0;
      active_flag  <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      done_flag <= 1'b0;
      case (state)
        ST_IDLE: begin
          active_flag <= 1'b0;
          if (!rx_s) begin
            state       <= ST_START;
            tick_cnt    <= '0;
            par_type_q  <= parity_type;
            active_flag <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt <= '0;
            if (rx_s) begin
              // Line went back high: glitch, not a frame.
              state       <= ST_IDLE;
              active_flag <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt == TICK_END) begin
            tick_cnt  <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= parity_enabled(par_type_q) ? ST_PARITY : ST_STOP;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tick_cnt == TICK_END) begin
            tick_cnt <= '0;
            par_bit  <= rx_s;
            state    <= ST_STOP;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_cnt == TICK_END) begin
            // Return to IDLE mid stop bit so a following start edge is caught.
            tick_cnt     <= '0;
            data_out     <= shift_reg;
            parity_error <= par_err_next;
            frame_error  <= ~rx_s;
            done_flag    <= 1'b1;
            active_flag  <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// Bench for uart_sipo_rx: directed frames plus a randomized frame stream,
// each frame scored against a line-level model of when and what the
// receiver must report.
module tb_uart_sipo_rx;

  localparam int OS   = 16;
  localparam int SYNC = 2;
  localparam int W    = 42;  // {done cycle[31:0], data[7:0], parity_error, frame_error}

  logic       baud_clk = 1'b0;
  logic       reset_n;
  logic       data_rx;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       done_flag;
  logic       active_flag;
  logic       parity_error;
  logic       frame_error;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] cyc = '0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  uart_sipo_rx #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(SYNC)
  ) dut (
    .baud_clk    (baud_clk),
    .reset_n     (reset_n),
    .data_rx     (data_rx),
    .parity_type (parity_type),
    .data_out    (data_out),
    .done_flag   (done_flag),
    .active_flag (active_flag),
    .parity_error(parity_error),
    .frame_error (frame_error)
  );

  // Clock and cycle counter.
  always #5 baud_clk = ~baud_clk;

  always @(posedge baud_clk) cyc <= cyc + 1;

  // Done monitor: capture every done cycle with the reported results.
  always @(negedge baud_clk) begin
    if (done_flag) obs_q.push_back({cyc, data_out, parity_error, frame_error});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge baud_clk);
      data_rx = 1'b1;
    end
  endtask

  // Drive one frame on the line (one bit = OS cycles, changes at negedges)
  // and queue the expected done event. abort_bit >= 0 stops half way
  // through that bit and queues nothing.
  task automatic send_frame(input logic [7:0] data, input logic [1:0] ptype,
                            input bit par_bad, input bit stop_bad,
                            input int abort_bit, input bit chk_active,
                            input bit chg_ptype);
    logic bits[0:10];
    int   nb;
    int   ones;
    int   c;
    bit   par_on;
    logic p;
    logic perr;
    par_on = (ptype == 2'b01) || (ptype == 2'b10);
    ones = $countones(data);
    // Odd parity: total ones (data + p) odd; even parity: total even.
    if (ptype == 2'b01) p = ((ones % 2) == 0);
    else                p = ((ones % 2) == 1);
    if (par_bad) p = ~p;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    nb = 9;
    if (par_on) begin
      bits[9] = p;
      nb = 10;
    end
    bits[nb] = ~stop_bad;
    perr = 1'b0;
    if (ptype == 2'b01) perr = ((ones + int'(p)) % 2) != 1;
    if (ptype == 2'b10) perr = ((ones + int'(p)) % 2) != 0;
    c = 0;
    for (int b = 0; b <= nb; b++) begin
      for (int k = 0; k < OS; k++) begin
        @(negedge baud_clk);
        if (k == 0) data_rx = bits[b];
        if (b == 0 && k == 0) begin
          c = int'(cyc);
          parity_type = ptype;
          // Line change is seen by the FSM SYNC+1 edges later (t0); the stop
          // sample is half a bit plus nb bits after t0; done shows right after.
          if (abort_bit < 0)
            exp_q.push_back({32'(c + SYNC + 1 + OS/2 + nb*OS), data, perr, stop_bad});
        end
        if (chk_active && b == 0 && k == SYNC)
          check("active_before_t0", 64'(active_flag), 64'(0));
        if (chk_active && b == 0 && k == SYNC + 1)
          check("active_at_t0", 64'(active_flag), 64'(1));
        if (chk_active && b == 5 && k == 0)
          check("active_mid_frame", 64'(active_flag), 64'(1));
        if (chg_ptype && b == 4 && k == 0) parity_type = 2'($urandom_range(0, 3));
        if (b == abort_bit && k == OS/2) return;
      end
    end
    if (stop_bad) begin
      @(negedge baud_clk);
      data_rx = 1'b1;
    end
  endtask

  // Scoreboard drain: compare observed done events against expectations.
  task automatic drain(input string tag);
    int waited;
    logic [W-1:0] e;
    logic [W-1:0] o;
    waited = 0;
    while (obs_q.size() < exp_q.size() && waited < 400) begin
      @(negedge baud_clk);
      waited++;
    end
    check({tag, "_done_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_done_cycle"}, 64'(o[41:10]), 64'(e[41:10]));
      check({tag, "_data"},       64'(o[9:2]),   64'(e[9:2]));
      check({tag, "_parity_err"}, 64'(o[1]),     64'(e[1]));
      check({tag, "_frame_err"},  64'(o[0]),     64'(e[0]));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    reset_n     = 1'b0;
    data_rx     = 1'b1;
    parity_type = 2'b00;
    repeat (4) @(negedge baud_clk);

    // Reset state.
    check("rst_data_out",  64'(data_out),     64'(0));
    check("rst_done",      64'(done_flag),    64'(0));
    check("rst_active",    64'(active_flag),  64'(0));
    check("rst_parity",    64'(parity_error), 64'(0));
    check("rst_frame",     64'(frame_error),  64'(0));
    reset_n = 1'b1;
    idle(10);

    // No parity, 0xA5, with active_flag timing.
    send_frame(8'hA5, 2'b00, 0, 0, -1, 1, 0);
    idle(4);
    check("a5_active_after", 64'(active_flag), 64'(0));
    drain("a5_none");

    // Odd parity, correct then wrong parity bit.
    send_frame(8'hA5, 2'b01, 0, 0, -1, 0, 0);
    idle(5);
    send_frame(8'hA5, 2'b01, 1, 0, -1, 0, 0);
    idle(5);
    drain("a5_odd");

    // Even parity on 0x07, then the same with stop bit forced low.
    send_frame(8'h07, 2'b10, 0, 0, -1, 0, 0);
    idle(5);
    send_frame(8'h07, 2'b10, 0, 1, -1, 0, 0);
    idle(20);
    drain("07_even");

    // 5-tick low glitch in IDLE: false start, outputs hold.
    @(negedge baud_clk);
    data_rx = 1'b0;
    repeat (4) @(negedge baud_clk);
    @(negedge baud_clk);
    data_rx = 1'b1;
    @(negedge baud_clk);
    check("glitch_active_hi", 64'(active_flag), 64'(1));
    idle(20);
    check("glitch_active_lo", 64'(active_flag), 64'(0));
    check("glitch_data_hold", 64'(data_out),    64'(8'h07));
    check("glitch_ferr_hold", 64'(frame_error), 64'(1));
    drain("glitch");

    // Back-to-back frames, single stop bit, no parity.
    send_frame(8'h3C, 2'b00, 0, 0, -1, 0, 0);
    send_frame(8'hC3, 2'b00, 0, 0, -1, 0, 0);
    idle(10);
    drain("b2b");

    // Reset during data bit 4 of 0x55; then 0x81 after release.
    send_frame(8'h55, 2'b00, 0, 0, 5, 0, 0);
    check("pre_rst_active", 64'(active_flag), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_data_out", 64'(data_out),     64'(0));
    check("mid_rst_active",   64'(active_flag),  64'(0));
    check("mid_rst_done",     64'(done_flag),    64'(0));
    check("mid_rst_parity",   64'(parity_error), 64'(0));
    check("mid_rst_frame",    64'(frame_error),  64'(0));
    data_rx = 1'b1;
    repeat (3) @(negedge baud_clk);
    reset_n = 1'b1;
    idle(10);
    send_frame(8'h81, 2'b00, 0, 0, -1, 0, 0);
    idle(5);
    drain("after_rst");

    // Randomized frame stream with mid-frame parity_type changes.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic [1:0] pt;
      bit pb;
      bit sb;
      bit chg;
      d   = 8'($urandom_range(0, 255));
      pt  = 2'($urandom_range(0, 3));
      pb  = ($urandom_range(0, 3) == 0);
      sb  = ($urandom_range(0, 5) == 0);
      chg = ($urandom_range(0, 1) == 1);
      send_frame(d, pt, pb, sb, -1, 0, chg);
      if (sb) idle(17 + int'($urandom_range(0, 8)));
      else    idle(int'($urandom_range(0, 12)));
    end
    idle(10);
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_sipo_rx.md
Name: uart_sipo_rx

Overview:
Receive-side frame decoder and serial-in/parallel-out shift register for the full-duplex UART. It pairs with the transmitter's PISO frame generator: same frame of start(0), 8 data bits LSB-first, optional parity and stop(1). It oversamples the serial line on baud_clk, which runs at OVERSAMPLE × bit rate and comes from the BaudGen unit. It checks parity and the stop bit, then presents the byte with a one-cycle done pulse.

Parameters:
OVERSAMPLE, 16, baud_clk ticks per bit; even, ≥4.
SYNC_STAGES, 2, flip-flop stages on data_rx before use; ≥2.

Ports:
baud_clk      input   1  oversampling clock, OVERSAMPLE × bit rate, from BaudGen.
reset_n       input   1  asynchronous, active-low reset.
data_rx       input   1  serial line, asynchronous, idles high.
parity_type   input   2  00 none, 01 odd, 10 even, 11 none; must match Tx. Sampled at start detection and held for the frame.
data_out      output  8  last received byte; holds until next completed frame.
done_flag     output  1  one-cycle pulse: frame finished, data_out/errors valid.
active_flag   output  1  high from start detection until return to IDLE.
parity_error  output  1  parity mismatch on last frame; held until next done.
frame_error   output  1  stop bit sampled 0 on last frame; held until next done.

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, synchronizer stages all 1, counters 0. Reset mid-frame discards the partial byte; no done pulse.
- rx_s is data_rx after SYNC_STAGES flops. All timing below is relative to t0, the first baud_clk edge where IDLE sees rx_s = 0.
- Tick counter tick_cnt is $clog2(OVERSAMPLE) bits; bit counter bit_cnt is 3 bits.
- FSM states and transitions:
  - IDLE: active_flag 0. On rx_s = 0, go to START, set tick_cnt 0, latch parity_type, set active_flag 1.
  - START: at tick OVERSAMPLE/2−1, sample rx_s (mid start bit).
    - 1 → false start: back to IDLE, active_flag 0, no done pulse, outputs unchanged.
    - 0 → go to DATA, reset tick_cnt and bit_cnt.
  - DATA: each time tick_cnt reaches OVERSAMPLE−1, shift rx_s into bit 7 of the shift register (right shift, LSB-first) and increment bit_cnt. After bit 7: go to PARITY if the latched type is 01/10, else STOP.
  - PARITY: sample after OVERSAMPLE ticks; store p.
  - STOP: sample after OVERSAMPLE ticks.
    - Same edge: data_out ← shift register.
    - parity_error ← (type 01: ^data ^ p != 1; type 10: ^data ^ p != 0; none: 0).
    - frame_error ← ~rx_s.
    - done_flag ← 1 for one cycle; go to IDLE; active_flag ← 0.
- Sample instants:
  - start: t0 + OVERSAMPLE/2.
  - data bit i: t0 + OVERSAMPLE/2 + (i+1)·OVERSAMPLE.
  - parity: t0 + OVERSAMPLE/2 + 9·OVERSAMPLE.
  - stop: one bit after the last data or parity sample.
- done_flag is high the cycle after the stop sample.
- Back-to-back frames: returning to IDLE mid stop bit means the next start edge is detected with no lost frames. If rx_s is still 0 after a frame_error, IDLE treats it as a new start (break condition repeatedly yields frames of 0x00 with frame_error=1).
- data_out, parity_error and frame_error update only on done; they are never cleared by false starts.
- parity_type changes mid-frame have no effect until the next frame.

Decomposition:
- Package uart_pkg:
  - parity encodings PAR_NONE0=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE1=2'b11 (shared with PISO/Parity unit);
  - state encoding IDLE/START/DATA/PARITY/STOP;
  - DATA_BITS=8.
- Sub-module uart_rx_sync: SYNC_STAGES-deep synchronizer with reset value 1. Everything else stays in uart_sipo_rx.

Test Plan:
- OVERSAMPLE=16, parity 00, send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) → done pulse at t0+8+9·16+1; data_out=0xA5, both errors 0; active_flag high t0+1 until the done cycle.
- Parity 01, 0xA5 with p=1 → parity_error=0. Repeat with p=0 → data_out=0xA5, parity_error=1.
- Parity 10, 0x07 with p=1 → parity_error=0. Stop bit forced 0 → frame_error=1, done still pulses.
- Low glitch of 5 ticks in IDLE → false start: no done pulse, active_flag returns 0, data_out keeps its previous value.
- Two frames 0x3C then 0xC3 back-to-back with a single stop bit, no parity → two done pulses 10·16 ticks apart; data_out 0x3C then 0xC3.
- reset_n asserted during bit 4 of frame 0x55 → all outputs 0 immediately. Next frame 0x81 received correctly after release.
